// File: rtl/servo_jog_ctrl.sv
// Two-axis jog controller: synchronised, debounced buttons step saturating X/Y duty words
// with auto-repeat while held; a home level recentres both axes.
module servo_jog_ctrl #(
    parameter int WIDTH           = 6,
    parameter int STEP            = 4,
    parameter int DUTY_MIN        = 0,
    parameter int DUTY_MAX        = 60,
    parameter int DUTY_HOME       = 32,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bt_up,
    input  logic             bt_down,
    input  logic             bt_left,
    input  logic             bt_right,
    input  logic             home,
    output logic [WIDTH-1:0] duty_x,
    output logic [WIDTH-1:0] duty_y,
    output logic [1:0]       lim_x,
    output logic [1:0]       lim_y,
    output logic             update
);
    localparam int WP   = WIDTH + 1;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0]    DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]    DLY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]    RATE_LAST = TW'(REPEAT_RATE - 1);
    localparam logic [WIDTH-1:0] STEP_N    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MIN_N     = WIDTH'(DUTY_MIN);
    localparam logic [WIDTH-1:0] MAX_N     = WIDTH'(DUTY_MAX);
    localparam logic [WIDTH-1:0] HOME_N    = WIDTH'(DUTY_HOME);
    localparam logic [WP-1:0]    STEP_W    = WP'(STEP);
    localparam logic [WP-1:0]    MIN_W     = WP'(DUTY_MIN);
    localparam logic [WP-1:0]    MAX_W     = WP'(DUTY_MAX);

    typedef enum logic [1:0] {IDLE, HELD_DELAY, HELD_REPEAT, LOCKOUT} state_t;

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur);
        logic [WP-1:0] sum;
        sum = {1'b0, cur} + STEP_W;
        return (sum > MAX_W) ? MAX_N : sum[WIDTH-1:0];
    endfunction

    // Compare before subtracting so the result clamps instead of wrapping.
    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] cur);
        return ({1'b0, cur} < (MIN_W + STEP_W)) ? MIN_N : (cur - STEP_N);
    endfunction

    function automatic logic [1:0] lim_of(input logic [WIDTH-1:0] cur);
        return {cur == MAX_N, cur == MIN_N};
    endfunction

    logic [4:0]       raw, sync1, sync2;
    logic [3:0]       deb, deb_prev;
    logic [CW-1:0]    cnt [4];
    state_t           state [2];
    logic [TW-1:0]    timer [2];
    logic [1:0]       dir_up;
    logic [WIDTH-1:0] duty [2];
    logic [1:0]       lim [2];
    logic [WIDTH-1:0] press_val [2];
    logic [WIDTH-1:0] held_val [2];
    logic [1:0]       pos_lvl, neg_lvl, pos_rise, neg_rise;
    logic             home_s;

    // Button order: right, left, up, down; X axis uses [1:0], Y axis uses [3:2].
    assign raw      = {home, bt_down, bt_up, bt_left, bt_right};
    assign home_s   = sync2[4];
    assign pos_lvl  = {deb[2], deb[0]};
    assign neg_lvl  = {deb[3], deb[1]};
    assign pos_rise = pos_lvl & ~{deb_prev[2], deb_prev[0]};
    assign neg_rise = neg_lvl & ~{deb_prev[3], deb_prev[1]};

    assign press_val[0] = pos_rise[0] ? step_up(duty[0]) : step_down(duty[0]);
    assign press_val[1] = pos_rise[1] ? step_up(duty[1]) : step_down(duty[1]);
    assign held_val[0]  = dir_up[0] ? step_up(duty[0]) : step_down(duty[0]);
    assign held_val[1]  = dir_up[1] ? step_up(duty[1]) : step_down(duty[1]);

    assign duty_x = duty[0];
    assign duty_y = duty[1];
    assign lim_x  = lim[0];
    assign lim_y  = lim[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            update <= 1'b0;
            dir_up <= '0;
            for (int a = 0; a < 2; a++) begin
                state[a] <= IDLE;
                timer[a] <= '0;
                duty[a]  <= HOME_N;
                lim[a]   <= lim_of(HOME_N);
            end
        end else begin
            update <= 1'b0;
            for (int a = 0; a < 2; a++) begin
                if (home_s) begin
                    state[a] <= LOCKOUT;
                    duty[a]  <= HOME_N;
                    lim[a]   <= lim_of(HOME_N);
                    if (duty[a] != HOME_N) update <= 1'b1;
                end else begin
                    case (state[a])
                        IDLE: begin
                            // A press while the opposing button is already down counts as a conflict.
                            if ((pos_rise[a] && neg_rise[a]) ||
                                (pos_rise[a] && neg_lvl[a]) || (neg_rise[a] && pos_lvl[a])) begin
                                state[a] <= LOCKOUT;
                            end else if (pos_rise[a] || neg_rise[a]) begin
                                state[a]  <= HELD_DELAY;
                                timer[a]  <= '0;
                                dir_up[a] <= pos_rise[a];
                                duty[a]   <= press_val[a];
                                lim[a]    <= lim_of(press_val[a]);
                                if (press_val[a] != duty[a]) update <= 1'b1;
                            end
                        end
                        HELD_DELAY, HELD_REPEAT: begin
                            if (!(dir_up[a] ? pos_lvl[a] : neg_lvl[a])) begin
                                state[a] <= IDLE;
                            end else if (dir_up[a] ? neg_lvl[a] : pos_lvl[a]) begin
                                state[a] <= LOCKOUT;
                            end else if (timer[a] == ((state[a] == HELD_DELAY) ? DLY_LAST : RATE_LAST)) begin
                                state[a] <= HELD_REPEAT;
                                timer[a] <= '0;
                                duty[a]  <= held_val[a];
                                lim[a]   <= lim_of(held_val[a]);
                                if (held_val[a] != duty[a]) update <= 1'b1;
                            end else begin
                                timer[a] <= timer[a] + 1'b1;
                            end
                        end
                        default: begin
                            if (!pos_lvl[a] && !neg_lvl[a]) state[a] <= IDLE;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/servo_jog_ctrl.md
# servo_jog_ctrl

Parametrised two-axis jog controller for the pan/tilt stage. It turns four raw push-buttons into registered X/Y duty-cycle words for the downstream PWM generators. It synchronises and debounces every button and steps once per press, with auto-repeat while a button is held. Results saturate at programmable limits. A home input recentres both axes. It replaces the unclocked, unbounded button-to-duty logic.

## Interface
- `WIDTH`, 6: duty word width.
- `STEP`, 4: increment/decrement per step, 1..2^WIDTH-1.
- `DUTY_MIN`, 0: lower saturation limit.
- `DUTY_MAX`, 60: upper saturation limit; DUTY_MIN <= DUTY_MAX <= 2^WIDTH-1.
- `DUTY_HOME`, 32: reset/home value; DUTY_MIN <= DUTY_HOME <= DUTY_MAX.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a level change, >= 1.
- `REPEAT_DELAY`, 12500000: cycles from first step to first repeat step, >= 1.
- `REPEAT_RATE`, 2500000: cycles between repeat steps, >= 1.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `bt_up`, `bt_down`, `bt_left`, `bt_right` input 1 each: raw asynchronous buttons, active-high.
- `home` input 1: raw asynchronous recentre request, active-high level.
- `duty_x`, `duty_y` output WIDTH: registered duty words.
- `lim_x`, `lim_y` output 2: registered limit flags; {at_max, at_min}.
- `update` output 1: one-cycle pulse on any cycle where duty_x or duty_y changed value.

## Operation
- **Synchronisation:** each of the five raw inputs passes through a 2-FF synchroniser.
- **Debounce (buttons only; home is not debounced):**
  - Each button has a counter.
  - The debounced level flips only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing sample clears the counter.
- **Axis pairs:** up/down drive Y; right/left drive X (up and right increase). Each axis has an independent FSM with states IDLE, HELD_DELAY, HELD_REPEAT, LOCKOUT.
  - IDLE -> HELD_DELAY on a rising edge of exactly one debounced axis button. Apply one step in that direction.
  - HELD_DELAY: after REPEAT_DELAY cycles, apply a step and go to HELD_REPEAT.
  - HELD_REPEAT: apply a step every REPEAT_RATE cycles.
  - Any held state -> IDLE when the held button's debounced level falls.
  - Any held state -> LOCKOUT when the opposing button's debounced level also goes high. No step is taken.
  - LOCKOUT -> IDLE only when both of the axis's debounced buttons are low.
  - Both buttons rising in the same cycle: IDLE -> LOCKOUT, no step.
- **Arithmetic:**
  - Sums are computed in WIDTH+1 bits.
  - Up: new = min(cur+STEP, DUTY_MAX).
  - Down: new = max(cur-STEP, DUTY_MIN). When cur < DUTY_MIN+STEP, the result is DUTY_MIN; it never wraps.
  - A step at a limit leaves the duty word unchanged and raises no `update`.
- **Limit flags:** at_max = (duty == DUTY_MAX); at_min = (duty == DUTY_MIN). Flags are registered with the duty word.
- **Home:**
  - While synchronised home = 1, both duty words are loaded with DUTY_HOME every cycle and both FSMs are forced to LOCKOUT. Home has priority over all buttons.
  - After home falls, any still-held button must be released before it can step again.
- **Reset:** reset_n = 0 asynchronously sets:
  - duty_x = duty_y = DUTY_HOME;
  - lim flags per DUTY_HOME;
  - update = 0;
  - FSMs = IDLE;
  - synchronisers, debounced levels and counters = 0.

## Timing
- **Button latency:** raw edge first sampled at edge E, synchroniser output valid at E+1. The debounced level changes at edge E+1+DEBOUNCE_CYCLES, and the duty word plus `update` change at edge E+2+DEBOUNCE_CYCLES.
- **Repeat cadence:** first step at cycle T, repeats at T+REPEAT_DELAY, then every REPEAT_RATE cycles.
- **Home latency:** raw home sampled at E; duty = DUTY_HOME at edge E+2. `update` pulses at that edge only if a value changed.
- **Independence:** X and Y may step in the same cycle; a single `update` pulse covers both.
- **No combinational paths:** no combinational path from any input to any output.

## Test plan
All scenarios use WIDTH=6, STEP=4, MIN=0, MAX=60, HOME=32, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- **Reset:** assert reset_n=0 mid-run, including mid-repeat. Required: duty_x = duty_y = 32, lim = 00 and update = 0 immediately, without waiting for a clock. After release, no step until a new press.
- **Single press:** hold bt_right for 10 cycles, then release. Required: duty_x goes 32 -> 36 exactly once, 6 edges after the first sampling edge, with one `update` pulse. No change on release.
- **Glitch rejection:** pulse bt_up high for 3 cycles, and separately bounce it (1-high/1-low toggling) for 20 cycles. Required: duty_y stays 32 and `update` never pulses.
- **Auto-repeat and saturation:** hold bt_up for 100 cycles. Required: duty_y = 36 at T, 40 at T+20, then +4 every 5 cycles through 60. Then lim_y = 10 and no further `update`. Repeat with bt_down from 2: the result is 0, with no wrap to 62.
- **Opposing buttons:** hold bt_left, then press bt_right during HELD_DELAY. Required: no further X steps. Release right only: still no steps. Release both, then press left: one step.
- **Home mid-repeat:** duty_x = 52 in HELD_REPEAT, then assert home for 3 cycles. Required: duty_x = duty_y = 32 two edges after sampling, with one `update` pulse. No steps while right stays held. Release and re-press right: 36.
